// File: rtl/eth_tx_fcs_seq.sv
// Ethernet transmit FCS sequencer: passes client bytes through, optionally zero-pads
// short frames to MIN_FRAME, then appends the 4-byte CRC-32 frame check sequence.
module eth_tx_fcs_seq #(
  parameter int MIN_FRAME = 60,
  parameter bit PAD_EN    = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  typedef enum logic [1:0] {
    DATA = 2'd0,
    PAD  = 2'd1,
    FCS  = 2'd2
  } state_e;

  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;

  state_e      state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic        done_q, done_d;
  logic [15:0] fcnt_q, fcnt_d;

  logic        fire;
  logic [16:0] cnt_inc;
  logic [15:0] cnt_sat;
  logic [16:0] min_len;

  // Serial MSB-first register fed with each byte LSB first, as it goes on the wire.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      fb = c[31] ^ d[i];
      c  = {c[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0000_0000);
    end
    return c;
  endfunction

  function automatic logic [7:0] fcs_byte(input logic [31:0] crc, input logic [1:0] k);
    logic [7:0] sel;
    logic [7:0] rev;
    case (k)
      2'd0:    sel = crc[31:24];
      2'd1:    sel = crc[23:16];
      2'd2:    sel = crc[15:8];
      default: sel = crc[7:0];
    endcase
    for (int i = 0; i < 8; i++) rev[i] = sel[7-i];
    return ~rev;
  endfunction

  assign cnt_inc = {1'b0, cnt_q} + 17'd1;
  assign cnt_sat = (&cnt_q) ? cnt_q : cnt_inc[15:0];
  assign min_len = 17'(MIN_FRAME);

  always_comb begin
    s_ready = 1'b0;
    m_valid = 1'b1;
    m_data  = 8'h00;
    m_last  = 1'b0;
    state_d = state_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    fcnt_d  = fcnt_q;

    unique case (state_q)
      DATA: begin
        s_ready = m_ready;
        m_valid = s_valid;
        m_data  = s_data;
      end
      PAD: ;
      FCS: begin
        m_data = fcs_byte(crc_q, idx_q);
        m_last = (idx_q == 2'd3);
      end
      default: ;
    endcase

    fire = m_valid && m_ready;

    // Nothing advances unless the downstream side takes the current byte.
    if (fire) begin
      unique case (state_q)
        DATA: begin
          crc_d = crc_byte(crc_q, s_data);
          cnt_d = cnt_sat;
          if (s_last) state_d = (PAD_EN && (cnt_inc < min_len)) ? PAD : FCS;
        end
        PAD: begin
          crc_d = crc_byte(crc_q, 8'h00);
          cnt_d = cnt_sat;
          if (cnt_inc >= min_len) state_d = FCS;
        end
        FCS: begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = DATA;
            idx_d   = 2'd0;
            crc_d   = CRC_INIT;
            cnt_d   = 16'd0;
            done_d  = 1'b1;
            fcnt_d  = fcnt_q + 16'd1;
          end
        end
        default: state_d = DATA;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= DATA;
      crc_q   <= CRC_INIT;
      cnt_q   <= 16'd0;
      idx_q   <= 2'd0;
      done_q  <= 1'b0;
      fcnt_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign busy       = (state_q != DATA) || (cnt_q != 16'd0);
  assign frame_done = done_q;
  assign frame_cnt  = fcnt_q;

endmodule
